// File: rtl/mac_result_drain.sv
// Drain stage for the MAC accumulator: counts terms, rounds and saturates each final
// sum, buffers results in a small FIFO and pulses clear_acc to restart the accumulator.
module mac_result_drain #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = 40,
    parameter int unsigned FRAC_SHIFT = 15,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ACC_WIDTH-1:0]  acc_in,
    input  logic                  acc_in_valid,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    output logic                  clear_acc,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sat_flag,
    output logic [7:0]            drop_cnt
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned RW    = ACC_WIDTH + 1;
    localparam int unsigned HI_W  = RW - DATA_WIDTH + 1;

    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d, len_q, len_d, len_eff;
    logic                  final_c;
    logic signed [RW-1:0]  rnd_sum, rnd_shift;
    logic [HI_W-1:0]       rnd_hi;
    logic                  conv_sat;
    logic [DATA_WIDTH-1:0] conv_data;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_q, rd_d, wr_q, wr_d, rd_nx;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full, push, pop, drop;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic                  valid_q;
    logic                  sat_q, sat_d;
    logic [7:0]            drop_q, drop_d;
    logic                  clr_q, rst_dly_q;

    // Term counting; the length is taken from cfg_len only on the first term
    always_comb begin
        len_eff = len_q;
        if (cnt_q == '0) begin
            len_eff = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
        end
        final_c = acc_in_valid && (cnt_q == len_eff - LEN_WIDTH'(1));
        cnt_d   = cnt_q;
        len_d   = len_q;
        if (acc_in_valid) begin
            len_d = len_eff;
            cnt_d = final_c ? '0 : cnt_q + LEN_WIDTH'(1);
        end
    end

    // Round half toward +inf, shift, then clip when the upper bits are not a sign extension
    always_comb begin
        rnd_sum   = $signed({acc_in[ACC_WIDTH-1], acc_in}) + $signed(RW'(1) << (FRAC_SHIFT - 1));
        rnd_shift = rnd_sum >>> FRAC_SHIFT;
        rnd_hi    = rnd_shift[RW-1:DATA_WIDTH-1];
        conv_sat  = !((&rnd_hi) || !(|rnd_hi));
        conv_data = rnd_shift[DATA_WIDTH-1:0];
        if (conv_sat) begin
            conv_data = rnd_shift[RW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                        : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

    // FIFO control; the head is kept in its own register so out_data is registered
    always_comb begin
        full    = (count_q == CNT_W'(FIFO_DEPTH));
        pop     = valid_q && out_ready;
        push    = final_c && (!full || pop);
        drop    = final_c && full && !pop;
        rd_nx   = rd_q + PTR_W'(1);
        rd_d    = pop  ? rd_nx : rd_q;
        wr_d    = push ? wr_q + PTR_W'(1) : wr_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        head_d = head_q;
        if (pop && (count_q > CNT_W'(1))) begin
            head_d = mem_q[rd_nx];
        end else if (push && ((count_q == '0) || (pop && (count_q == CNT_W'(1))))) begin
            head_d = conv_data;
        end
        sat_d  = sat_q || (final_c && conv_sat);
        drop_d = (drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            len_q     <= LEN_WIDTH'(1);
            rd_q      <= '0;
            wr_q      <= '0;
            count_q   <= '0;
            head_q    <= '0;
            valid_q   <= 1'b0;
            sat_q     <= 1'b0;
            drop_q    <= '0;
            clr_q     <= 1'b1;
            rst_dly_q <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            count_q   <= count_d;
            head_q    <= head_d;
            valid_q   <= (count_d != '0);
            sat_q     <= sat_d;
            drop_q    <= drop_d;
            clr_q     <= rst_dly_q || final_c;
            rst_dly_q <= 1'b0;
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= conv_data;
        end
    end

    assign clear_acc = clr_q;
    assign out_data  = head_q;
    assign out_valid = valid_q;
    assign sat_flag  = sat_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_mac_result_drain.sv
// Bench for mac_result_drain: queue-based model checked every cycle plus directed literals.
module tb_mac_result_drain;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 40;
    localparam int unsigned FS = 15;
    localparam int unsigned LW = 8;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] acc_in;
    logic          acc_in_valid;
    logic [LW-1:0] cfg_len;
    logic          clear_acc;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          sat_flag;
    logic [7:0]    drop_cnt;

    int checks   = 0;
    int failures = 0;
    int clr_seen = 0;

    mac_result_drain #(
        .DATA_WIDTH(DW), .ACC_WIDTH(AW), .FRAC_SHIFT(FS), .LEN_WIDTH(LW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .acc_in(acc_in), .acc_in_valid(acc_in_valid),
        .cfg_len(cfg_len), .clear_acc(clear_acc), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .sat_flag(sat_flag),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference conversion in plain integer arithmetic
    function automatic longint conv(input longint a, output bit s);
        longint r;
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (DW - 1)) - 1;
        lo = -(longint'(1) <<< (DW - 1));
        r  = (a + (longint'(1) <<< (FS - 1))) >>> FS;
        s  = 1'b0;
        if (r > hi) begin r = hi; s = 1'b1; end
        if (r < lo) begin r = lo; s = 1'b1; end
        return r;
    endfunction

    // Behavioural model state
    longint m_q[$];
    int     m_cnt = 0;
    int     m_len = 1;
    bit     m_sat = 0;
    int     m_drop = 0;
    bit     m_clr = 0;
    bit     m_prev_rst = 0;
    bit     m_init = 0;

    always @(posedge clk) begin
        bit     fin;
        bit     s;
        longint v;
        longint tmp;
        fin = 1'b0;
        if (rst) begin
            m_q.delete();
            m_cnt = 0;
            m_sat = 0;
            m_drop = 0;
            m_clr = 1;
            m_prev_rst = 1;
            m_init = 1;
        end else begin
            if (acc_in_valid) begin
                if (m_cnt == 0) m_len = (cfg_len == 0) ? 1 : int'(cfg_len);
                m_cnt++;
                if (m_cnt == m_len) begin
                    fin = 1'b1;
                    m_cnt = 0;
                end
            end
            if (m_q.size() > 0 && out_ready) tmp = m_q.pop_front();
            if (fin) begin
                v = conv(longint'($signed(acc_in)), s);
                if (s) m_sat = 1;
                if (m_q.size() < DEPTH) m_q.push_back(v);
                else if (m_drop < 255) m_drop++;
            end
            m_clr = m_prev_rst || fin;
            m_prev_rst = 0;
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("m_clear_acc", longint'(clear_acc), longint'(m_clr));
            chk("m_out_valid", longint'(out_valid), longint'(m_q.size() > 0));
            chk("m_sat_flag", longint'(sat_flag), longint'(m_sat));
            chk("m_drop_cnt", longint'(drop_cnt), longint'(m_drop));
            if (m_q.size() > 0) chk("m_out_data", longint'($signed(out_data)), m_q[0]);
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input longint v);
        acc_in = AW'(v);
        acc_in_valid = 1'b1;
        step();
        acc_in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 10 && out_valid; i++) step();
        chk("drain_done", longint'(out_valid), 0);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        acc_in = '0;
        acc_in_valid = 1'b0;
        cfg_len = 8'd1;
        out_ready = 1'b0;

        repeat (3) begin step(); if (clear_acc) clr_seen++; end
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_data", longint'(out_data), 0);
        chk("rst_drop_cnt", longint'(drop_cnt), 0);
        chk("rst_sat_flag", longint'(sat_flag), 0);
        rst = 1'b0;
        repeat (3) begin step(); if (clear_acc) clr_seen++; end
        chk("rst_clear_cycles", clr_seen, 4);

        // Basic rounding: 98304 + 16384 = 114688, >>15 = 3
        cfg_len = 8'd3;
        acc_in_valid = 1'b1;
        acc_in = AW'(100);   step();
        acc_in = AW'(200);   step();
        acc_in = AW'(98304); step();
        acc_in_valid = 1'b0;
        chk("round_3", longint'($signed(out_data)), 3);
        chk("round_valid", longint'(out_valid), 1);
        chk("round_clear_pulse", longint'(clear_acc), 1);
        step();
        chk("round_clear_end", longint'(clear_acc), 0);
        drain();

        cfg_len = 8'd1;
        send(16384);  chk("round_tie_pos", longint'($signed(out_data)), 1); drain();
        send(-16384); chk("round_tie_neg", longint'($signed(out_data)), 0); drain();

        // Saturation
        send(longint'(1) <<< 31);
        chk("sat_pos", longint'($signed(out_data)), 32767);
        chk("sat_flag_set", longint'(sat_flag), 1);
        drain();
        send(-(longint'(1) <<< 31));
        chk("sat_neg", longint'($signed(out_data)), -32768);
        drain();
        send(longint'(5) <<< 15);
        chk("in_range_5", longint'($signed(out_data)), 5);
        chk("sat_sticky", longint'(sat_flag), 1);
        drain();

        // Backpressure: six results into a four-entry buffer
        acc_in_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            acc_in = AW'(longint'(k) <<< 15);
            step();
        end
        acc_in_valid = 1'b0;
        chk("bp_drop_cnt", longint'(drop_cnt), 2);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("bp_order", longint'($signed(out_data)), k);
            step();
        end
        chk("bp_empty", longint'(out_valid), 0);
        out_ready = 1'b0;

        // Full buffer with simultaneous pop and push
        for (int k = 10; k <= 13; k++) send(longint'(k) <<< 15);
        out_ready = 1'b1;
        send(longint'(14) <<< 15);
        out_ready = 1'b0;
        chk("full_pp_head", longint'($signed(out_data)), 11);
        chk("full_pp_drop", longint'(drop_cnt), 2);
        out_ready = 1'b1;
        for (int k = 11; k <= 14; k++) begin
            chk("full_pp_order", longint'($signed(out_data)), k);
            step();
        end
        chk("full_pp_empty", longint'(out_valid), 0);
        out_ready = 1'b0;

        // Mid-product reset
        cfg_len = 8'd4;
        send(longint'(1) <<< 15);
        send(longint'(2) <<< 15);
        rst = 1'b1;
        step();
        rst = 1'b0;
        cfg_len = 8'd2;
        send(longint'(3) <<< 15);
        send(longint'(5) <<< 15);
        chk("midrst_data", longint'($signed(out_data)), 5);
        chk("midrst_drop_clr", longint'(drop_cnt), 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("midrst_single", longint'(out_valid), 0);

        // cfg_len change after the first term must not shorten the product
        cfg_len = 8'd3;
        send(longint'(1) <<< 15);
        cfg_len = 8'd1;
        send(longint'(2) <<< 15);
        chk("len_latch_none", longint'(out_valid), 0);
        send(longint'(7) <<< 15);
        chk("len_latch_data", longint'($signed(out_data)), 7);
        send(longint'(8) <<< 15);
        out_ready = 1'b1;
        chk("len_new_a", longint'($signed(out_data)), 7);
        step();
        chk("len_new_b", longint'($signed(out_data)), 8);
        step();
        chk("len_new_empty", longint'(out_valid), 0);
        out_ready = 1'b0;

        // Drop counter saturates at 255
        acc_in_valid = 1'b1;
        for (int i = 0; i < 262; i++) begin
            acc_in = AW'(longint'(i) <<< 10);
            step();
        end
        acc_in_valid = 1'b0;
        chk("drop_saturate", longint'(drop_cnt), 255);
        chk("drop_fifo_full", longint'(out_valid), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
